// File: rtl/return_stack_pkg.sv
// return_stack_pkg: shared address width and stack depth constants
package return_stack_pkg;
    localparam int PC_WIDTH = 10;
    localparam int STACK_DEPTH = 16;
endpackage

// File: rtl/return_stack_mem.sv
// stack_mem: DEPTH x WIDTH array, synchronous write, asynchronous read
module stack_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/return_stack.sv
// return_stack: LIFO of return addresses with zero-latency top and sticky ovf/unf flags
module return_stack
    import return_stack_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    localparam int LW = $clog2(DEPTH+1),
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);
    logic             we;
    logic [AW-1:0]    waddr;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic [LW-1:0]    level_nx;
    assign empty = level == '0;
    assign full  = level == LW'(DEPTH);
    assign raddr = AW'(level - 1'b1);
    // push+pop on a non-empty stack rewrites the current top in place
    assign we    = push && (pop || !full);
    assign waddr = (push && pop && !empty) ? raddr : AW'(level);
    assign top   = empty ? '0 : rdata;
    always_comb
        level_nx = (push && !pop && !full) ? level + 1'b1 :
                   (pop && !push && !empty) ? level - 1'b1 :
                   (push && pop && empty) ? LW'(1) : level;
    always_ff @(posedge clk)
        if (reset) begin
            level <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            level <= level_nx;
            ovf   <= ovf | (push & ~pop & full);
            unf   <= unf | (pop & empty);
        end
    stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
        .clk(clk), .we(we), .waddr(waddr), .wdata(din), .raddr(raddr), .rdata(rdata)
    );
endmodule
